// File: rtl/turbo_enc_pkg.sv
// Shared constants for the turbo encoder core: FSM codes, block lengths and counter sizing.
// Block lengths shrink to 128/64 when SHORT_TEST_BLOCK_EN is defined.
package turbo_enc_pkg;

   localparam int CNT_W       = 13;
   localparam int TRELLIS_LEN = 4;

   typedef logic [2:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE    = 3'd0;
   localparam fsm_state_t ST_ENCODE  = 3'd1;
   localparam fsm_state_t ST_TRELLIS = 3'd2;

`ifdef SHORT_TEST_BLOCK_EN
   localparam logic [CNT_W-1:0] K_LONG  = 13'd128;
   localparam logic [CNT_W-1:0] K_SHORT = 13'd64;
`else
   localparam logic [CNT_W-1:0] K_LONG  = 13'd6144;
   localparam logic [CNT_W-1:0] K_SHORT = 13'd1056;
`endif

   // Index of the final information bit for the selected block size.
   function automatic logic [CNT_W-1:0] block_last(input logic long_sel);
      return (long_sel ? K_LONG : K_SHORT) - 13'd1;
   endfunction

endpackage

// File: rtl/rsc_encoder.sv
// 8-state recursive systematic convolutional encoder (feedback s2^s3, parity a^s1^s3).
// The enclosing core derives termination bits from the exported state.
module rsc_encoder
   import turbo_enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       u,
   input  logic       enable,
   input  logic       clear,
   output logic       x,
   output logic       z,
   output logic [2:0] state
);

   logic s1, s2, s3;
   logic a;

   assign a     = u ^ s2 ^ s3;
   assign x     = u;
   assign z     = a ^ s1 ^ s3;
   assign state = {s1, s2, s3};

   // Shift register advances only on accepted bits; clear returns it to the all-zero state.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else if (enable) begin
         s1 <= a;
         s2 <= s1;
         s3 <= s2;
      end
   end

endmodule

// File: rtl/turbo_enc_core.sv
// Turbo encoder core: two RSC encoders, block FSM and trellis termination output mux.
// Optional macro SHORT_TEST_BLOCK_EN selects short block lengths (see turbo_enc_pkg).
module turbo_enc_core
   import turbo_enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       data_valid,
   input  logic       ck,
   input  logic       ckp,
   input  logic       length,
   output logic       ready,
   output logic       xk,
   output logic       zk,
   output logic       zkp,
   output logic       out_valid,
   output logic       tail,
   output logic [2:0] current_state
);

   fsm_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             len_q;

   logic       accept;
   logic       clear_enc;
   logic       x1, z1, z2;
   logic       x2_unused;
   logic [2:0] st1, st2;

   assign ready         = (state_q == ST_IDLE) || (state_q == ST_ENCODE);
   assign current_state = state_q;
   assign accept        = data_valid && ready;
   assign clear_enc     = (state_q == ST_TRELLIS) && (cnt_q == CNT_W'(TRELLIS_LEN - 1));

   rsc_encoder u_enc1 (
      .clk    (clk),
      .rst    (rst),
      .u      (ck),
      .enable (accept),
      .clear  (clear_enc),
      .x      (x1),
      .z      (z1),
      .state  (st1)
   );

   rsc_encoder u_enc2 (
      .clk    (clk),
      .rst    (rst),
      .u      (ckp),
      .enable (accept),
      .clear  (clear_enc),
      .x      (x2_unused),
      .z      (z2),
      .state  (st2)
   );

   // Termination bits per encoder from the held state {s1,s2,s3}: x0,z0,x1,z1,x2,z2.
   logic [5:0] term1, term2;
   assign term1 = {st1[1] ^ st1[0], st1[2] ^ st1[0], st1[2] ^ st1[1], st1[1], st1[2], st1[2]};
   assign term2 = {st2[1] ^ st2[0], st2[2] ^ st2[0], st2[2] ^ st2[1], st2[1], st2[2], st2[2]};

   // Block FSM; outputs are registered so each triplet appears one cycle after its source.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= 1'b0;
         xk        <= 1'b0;
         zk        <= 1'b0;
         zkp       <= 1'b0;
         out_valid <= 1'b0;
         tail      <= 1'b0;
      end else begin
         xk        <= 1'b0;
         zk        <= 1'b0;
         zkp       <= 1'b0;
         out_valid <= 1'b0;
         tail      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (data_valid) begin
                  len_q     <= length;
                  cnt_q     <= CNT_W'(1);
                  state_q   <= ST_ENCODE;
                  out_valid <= 1'b1;
                  xk        <= x1;
                  zk        <= z1;
                  zkp       <= z2;
               end
            end
            ST_ENCODE: begin
               if (data_valid) begin
                  out_valid <= 1'b1;
                  xk        <= x1;
                  zk        <= z1;
                  zkp       <= z2;
                  if (cnt_q == block_last(len_q)) begin
                     cnt_q   <= '0;
                     state_q <= ST_TRELLIS;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_TRELLIS: begin
               out_valid <= 1'b1;
               tail      <= 1'b1;
               case (cnt_q[1:0])
                  2'd0:    {xk, zk, zkp} <= term1[5:3];
                  2'd1:    {xk, zk, zkp} <= term1[2:0];
                  2'd2:    {xk, zk, zkp} <= term2[5:3];
                  default: {xk, zk, zkp} <= term2[2:0];
               endcase
               if (clear_enc) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turbo_enc_core.sv
// Self-checking bench for turbo_enc_core: polynomial-form reference model compared every
// cycle, plus literal expectations for zero, impulse, last-bit, reset and back-to-back blocks.
module tb_turbo_enc_core;

`ifdef SHORT_TEST_BLOCK_EN
   localparam int K_L = 128;
   localparam int K_S = 64;
`else
   localparam int K_L = 6144;
   localparam int K_S = 1056;
`endif

   logic       clk = 1'b0;
   logic       rst, data_valid, ck, ckp, length;
   logic       ready, xk, zk, zkp, out_valid, tail;
   logic [2:0] current_state;

   always #5 clk = ~clk;

   turbo_enc_core dut (
      .clk           (clk),
      .rst           (rst),
      .data_valid    (data_valid),
      .ck            (ck),
      .ckp           (ckp),
      .length        (length),
      .ready         (ready),
      .xk            (xk),
      .zk            (zk),
      .zkp           (zkp),
      .out_valid     (out_valid),
      .tail          (tail),
      .current_state (current_state)
   );

   typedef struct {
      bit ov;
      bit tl;
      bit x;
      bit z;
      bit zp;
      bit rdy;
      int st;
   } exp_t;

   exp_t     expQ[$];
   logic [3:0] outLog[$];
   int       checks = 0;
   int       errors = 0;
   int       readyLowCnt = 0;
   bit       countReady = 0;

   // Reference model: feedback sequence a[n] = u[n]^a[n-2]^a[n-3], parity a[n]^a[n-1]^a[n-3].
   int       mPhase = 0;
   int       mK = 0;
   int       mCount = 0;
   int       mTrIdx = 0;
   bit       aHist[2][8192];
   bit [2:0] mTail[4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit aGet(input int e, input int i);
      return (i < 0) ? 1'b0 : aHist[e][i];
   endfunction

   function automatic bit encodeBit(input int e, input bit u);
      bit a;
      a = u ^ aGet(e, mCount - 2) ^ aGet(e, mCount - 3);
      aHist[e][mCount] = a;
      return a ^ aGet(e, mCount - 1) ^ aGet(e, mCount - 3);
   endfunction

   function automatic void buildTail();
      bit tx[3];
      bit tz[3];
      for (int e = 0; e < 2; e++) begin
         for (int j = 0; j < 3; j++) begin
            aHist[e][mK + j] = 1'b0;
            tx[j] = aGet(e, mK + j - 2) ^ aGet(e, mK + j - 3);
            tz[j] = aGet(e, mK + j - 1) ^ aGet(e, mK + j - 3);
         end
         mTail[2*e]     = {tx[0], tz[0], tx[1]};
         mTail[2*e + 1] = {tz[1], tx[2], tz[2]};
      end
   endfunction

   function automatic bit modelStep(input bit r, input bit dv, input bit u1, input bit u2, input bit ln);
      exp_t e;
      bit   acc;
      e.ov = 0; e.tl = 0; e.x = 0; e.z = 0; e.zp = 0;
      acc = 0;
      if (r) begin
         mPhase = 0;
      end else if (mPhase == 2) begin
         e.ov = 1;
         e.tl = 1;
         {e.x, e.z, e.zp} = mTail[mTrIdx];
         mTrIdx++;
         if (mTrIdx == 4) mPhase = 0;
      end else if (dv) begin
         if (mPhase == 0) begin
            mK = ln ? K_L : K_S;
            mCount = 0;
            mPhase = 1;
         end
         e.ov = 1;
         e.x  = u1;
         e.z  = encodeBit(0, u1);
         e.zp = encodeBit(1, u2);
         acc  = 1;
         mCount++;
         if (mCount == mK) begin
            buildTail();
            mPhase = 2;
            mTrIdx = 0;
         end
      end
      e.st  = mPhase;
      e.rdy = (mPhase != 2);
      expQ.push_back(e);
      return acc;
   endfunction

   // Drive one cycle of inputs, record the model's view of the next output, advance one edge.
   task automatic applyStimulus(input bit r, input bit dv, input bit u1, input bit u2, input bit ln, output bit acc);
      rst        = r;
      data_valid = dv;
      ck         = u1;
      ckp        = u2;
      length     = ln;
      acc        = modelStep(r, dv, u1, u2, ln);
      @(posedge clk);
      #1;
   endtask

   function automatic bit patCk(input int pat, input int idx, input int K);
      case (pat)
         1:       return idx == 0;
         2:       return idx == K - 1;
         3:       return ((idx * 13 + idx / 7) % 3) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit patCkp(input int pat, input int idx);
      return (pat == 3) ? (((idx * 5 + 1) % 4) < 2) : 1'b0;
   endfunction

   task automatic driveBlock(input bit ln, input int pat, input bit toggle, input int rstAt);
      int K;
      int idx;
      int cyc;
      bit acc;
      bit dv;
      K = ln ? K_L : K_S;
      idx = 0;
      cyc = 0;
      while (idx < K) begin
         if (idx == rstAt) begin
            applyStimulus(1, 1, 1, 1, ln, acc);
            return;
         end
         dv = toggle ? ((cyc % 2) == 0) : 1'b1;
         applyStimulus(0, dv, patCk(pat, idx, K), patCkp(pat, idx), ln, acc);
         if (acc) idx++;
         cyc++;
         if (cyc > 4 * K + 20) begin
            checkOutput("block_cycle_bound", cyc, 4 * K + 20);
            return;
         end
      end
   endtask

   task automatic idleCycles(input int n, input bit dv);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(0, dv, 1'b1, 1'b1, 1'b0, acc);
   endtask

   task automatic checkZeroBlock(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < outLog.size(); i++)
         if (outLog[i] !== ((i >= K_S) ? 4'b1000 : 4'b0000)) bad++;
      checkOutput({tag, "_count"}, outLog.size(), K_S + 4);
      checkOutput({tag, "_bad_triplets"}, bad, 0);
   endtask

   // Single compare process: every cycle's outputs against the model's expectation.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("out_valid", out_valid, e.ov);
         checkOutput("tail", tail, e.tl);
         checkOutput("xk", xk, e.x);
         checkOutput("zk", zk, e.z);
         checkOutput("zkp", zkp, e.zp);
         checkOutput("ready", ready, e.rdy);
         checkOutput("current_state", current_state, e.st);
         if (out_valid === 1'b1) outLog.push_back({tail, xk, zk, zkp});
         if (countReady && ready !== 1'b1) readyLowCnt++;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          acc;
      logic [3:0]  contLog[$];
      logic [6:0]  zFirst;
      int          diffs;
      int          ones;
      int          tails;
      int          base;

      rst = 1'b1; data_valid = 1'b0; ck = 1'b0; ckp = 1'b0; length = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, acc);
      applyStimulus(1, 1, 1, 1, 1, acc);
      idleCycles(2, 0);

      $display("[TB] all-zero short block");
      outLog.delete();
      driveBlock(0, 0, 0, -1);
      idleCycles(6, 0);
      checkZeroBlock("zero_block");

      $display("[TB] impulse response");
      outLog.delete();
      driveBlock(0, 1, 0, -1);
      idleCycles(6, 0);
      for (int i = 0; i < 7; i++) zFirst[6 - i] = outLog[i][1];
      checkOutput("impulse_z_first7", zFirst, 7'b1111001);
      ones = 0;
      for (int i = 0; i < K_S; i++) ones += outLog[i][2];
      checkOutput("impulse_x_ones", ones, 1);
      checkOutput("impulse_x0", outLog[0][2], 1);
      diffs = 0;
      for (int i = 1; i < 60; i++) if (outLog[i][1] !== outLog[i + 7][1]) diffs++;
      checkOutput("impulse_z_period7", diffs, 0);

      $display("[TB] last bit set, junk data_valid during termination");
      outLog.delete();
      driveBlock(0, 2, 0, -1);
      idleCycles(4, 1);
      idleCycles(4, 0);
      checkOutput("lastbit_count", outLog.size(), K_S + 4);
      checkOutput("lastbit_tail0", outLog[K_S], 4'b1011);
      checkOutput("lastbit_tail1", outLog[K_S + 1], 4'b1011);
      checkOutput("lastbit_tail2", outLog[K_S + 2], 4'b1000);
      checkOutput("lastbit_tail3", outLog[K_S + 3], 4'b1000);

      $display("[TB] continuous versus gapped data_valid");
      outLog.delete();
      driveBlock(0, 3, 0, -1);
      idleCycles(6, 0);
      contLog = outLog;
      outLog.delete();
      driveBlock(0, 3, 1, -1);
      idleCycles(6, 0);
      checkOutput("gapped_count", outLog.size(), K_S + 4);
      diffs = 0;
      for (int i = 0; i < outLog.size() && i < contLog.size(); i++)
         if (outLog[i] !== contLog[i]) diffs++;
      checkOutput("gapped_vs_continuous", diffs, 0);

      $display("[TB] reset at bit 500");
      driveBlock(0, 3, 0, 500);
      outLog.delete();
      idleCycles(6, 0);
      checkOutput("reset_no_tail", outLog.size(), 0);
      outLog.delete();
      driveBlock(0, 0, 0, -1);
      idleCycles(6, 0);
      checkZeroBlock("post_reset_block");

      $display("[TB] back-to-back long then short block");
      outLog.delete();
      readyLowCnt = 0;
      countReady = 1;
      driveBlock(1, 3, 0, -1);
      driveBlock(0, 3, 0, -1);
      countReady = 0;
      idleCycles(6, 0);
      checkOutput("b2b_ready_low", readyLowCnt, 4);
      checkOutput("b2b_count", outLog.size(), K_L + K_S + 8);
      tails = 0;
      for (int i = 0; i < outLog.size(); i++) tails += outLog[i][3];
      checkOutput("b2b_tails", tails, 8);
      base = K_L + 4 + K_S;
      checkOutput("b2b_second_last_data", outLog[base - 1][3], 0);
      checkOutput("b2b_second_first_tail", outLog[base][3], 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
